mem_arbiter: RTL and testbench

- Two-master arbiter in front of the single physical-memory port of phy_mem_ctrl.
- Master 0 is the CPU memory port. Master 1 is a DMA-style requester, e.g. the planned sl811/VGA block-copy engine.
- Sequences one outstanding access at a time onto the shared addr/data/is_write/busy interface, using round-robin grant, and routes read data and completion back to the winning master.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, mem_arbiter and phy_mem_ctrl.
// slave: arbiter view. master: requester/memory-side view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_is_write;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_is_write;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              grant;
  logic              dev_req;
  logic [ADDR_W-1:0] dev_addr;
  logic              dev_is_write;
  logic [DATA_W-1:0] dev_data_out;
  logic [DATA_W-1:0] dev_data_in;
  logic              dev_busy;
  logic              err;

  modport slave (
    input  m0_req, m0_addr, m0_is_write, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_addr, m1_is_write, m1_wdata,
    output m1_rdata, m1_ack,
    output grant, dev_req, dev_addr, dev_is_write, dev_data_out, err,
    input  dev_data_in, dev_busy
  );

  modport master (
    output m0_req, m0_addr, m0_is_write, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_addr, m1_is_write, m1_wdata,
    input  m1_rdata, m1_ack,
    input  grant, dev_req, dev_addr, dev_is_write, dev_data_out, err,
    output dev_data_in, dev_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sequencing one access at a time onto phy_mem_ctrl.
// Define MEM_ARB_TIMEOUT_EN to abort accesses whose dev_busy outlasts TIMEOUT cycles (sets sticky err).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic         clk50M,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  // Handshake: m*_req is a level held (with addr/wdata) until the one-cycle m*_ack;
  // dev_req is a one-cycle start strobe, and dev_busy low from the second WAIT cycle on ends the access.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              last;
  logic              first_wait;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_is_write;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [9:0]        TO_LAST    = 10'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);
  logic [9:0] to_cnt;
  logic       err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign dbg_state = state;

  // Master 1 wins when it is alone, or on a tie when master 0 was served last.
  always_comb begin
    sel          = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
    sel_addr     = sel ? bus.m1_addr     : bus.m0_addr;
    sel_is_write = sel ? bus.m1_is_write : bus.m0_is_write;
    sel_wdata    = sel ? bus.m1_wdata    : bus.m0_wdata;
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      last             <= 1'b1;
      first_wait       <= 1'b0;
      bus.grant        <= 1'b0;
      bus.dev_req      <= 1'b0;
      bus.dev_addr     <= '0;
      bus.dev_is_write <= 1'b0;
      bus.dev_data_out <= '0;
      bus.m0_rdata     <= '0;
      bus.m1_rdata     <= '0;
      bus.m0_ack       <= 1'b0;
      bus.m1_ack       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt           <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      bus.dev_req <= 1'b0;
      bus.m0_ack  <= 1'b0;
      bus.m1_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            bus.grant        <= sel;
            bus.dev_addr     <= sel_addr;
            bus.dev_is_write <= sel_is_write;
            bus.dev_data_out <= sel_wdata;
            bus.dev_req      <= 1'b1;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          first_wait <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt     <= '0;
`endif
          state      <= S_WAIT;
        end
        S_WAIT: begin
          first_wait <= 1'b0;
          // The memory cannot raise busy before the second WAIT cycle.
          if (!first_wait && !bus.dev_busy) begin
            if (!bus.dev_is_write) begin
              if (bus.grant) bus.m1_rdata <= bus.dev_data_in;
              else           bus.m0_rdata <= bus.dev_data_in;
            end
            bus.m0_ack <= ~bus.grant;
            bus.m1_ack <= bus.grant;
            state      <= S_DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (bus.dev_busy) begin
            if (to_cnt == TO_LAST) begin
              if (!bus.dev_is_write) begin
                if (bus.grant) bus.m1_rdata <= ABORT_DATA;
                else           bus.m0_rdata <= ABORT_DATA;
              end
              bus.m0_ack <= ~bus.grant;
              bus.m1_ack <= bus.grant;
              err_q      <= 1'b1;
              state      <= S_DONE;
            end else begin
              to_cnt <= to_cnt + 10'd1;
            end
          end
`endif
        end
        S_DONE: begin
          last  <= bus.grant;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses, round-robin contention, reset abort,
// and (with MEM_ARB_TIMEOUT_EN, TIMEOUT=8) the busy timeout.
module tb_mem_arbiter;
  logic       clk50M = 1'b0;
  logic       rst    = 1'b0;
  logic [1:0] dbg_state;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #10 clk50M = ~clk50M;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] exp_dev_q [$];  // {is_write, addr, wdata}
  logic [32:0] exp_ack_q [$];  // {master, rdata}
  logic [31:0] mem_data_q [$];
  logic [31:0] model_rdata [2];
  logic [31:0] exp_rdata [2];
  int          mem_busy_cycles;
  int          busy_left;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an output event, expected none pending", name);
  endtask

  // memory model: busy for mem_busy_cycles after each dev_req, read data from mem_data_q
  always @(negedge clk50M) begin
    if (!rst) begin
      bus.dev_busy    = 1'b0;
      bus.dev_data_in = 32'h0;
      busy_left       = 0;
    end else if (bus.dev_req) begin
      busy_left    = mem_busy_cycles;
      bus.dev_busy = (busy_left > 0);
      if (!bus.dev_is_write && mem_data_q.size() > 0) bus.dev_data_in = mem_data_q.pop_front();
      else                                            bus.dev_data_in = 32'hFFFF_FFFF;
    end else if (busy_left > 0) begin
      busy_left--;
      bus.dev_busy = (busy_left > 0);
    end
  end

  // scoreboard monitor
  always @(negedge clk50M) begin
    logic [64:0] ed;
    logic [32:0] ea;
    int          m;
    if (!rst) begin
      exp_rdata[0] = 32'h0;
      exp_rdata[1] = 32'h0;
    end else begin
      if (bus.dev_req) begin
        if (exp_dev_q.size() == 0) fail_event("dev_req_unexpected");
        else begin
          ed = exp_dev_q.pop_front();
          check("dev_cmd", {bus.dev_is_write, bus.dev_addr, bus.dev_data_out}, ed);
        end
      end
      if (bus.m0_ack || bus.m1_ack) begin
        check("ack_single", bus.m0_ack & bus.m1_ack, 1'b0);
        if (exp_ack_q.size() == 0) fail_event("ack_unexpected");
        else begin
          ea = exp_ack_q.pop_front();
          m  = bus.m1_ack ? 1 : 0;
          check("ack_master", bus.m1_ack, ea[32]);
          check("ack_grant", bus.grant, ea[32]);
          check("ack_rdata", m ? bus.m1_rdata : bus.m0_rdata, ea[31:0]);
          exp_rdata[m] = ea[31:0];
          check("other_rdata_hold", m ? bus.m0_rdata : bus.m1_rdata, exp_rdata[1-m]);
        end
      end
    end
  end

  // driver tasks
  task automatic expect_access(input int m, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [31:0] rd);
    exp_dev_q.push_back({wr, addr, wdata});
    if (!wr) mem_data_q.push_back(rd);
    exp_ack_q.push_back({m[0], wr ? model_rdata[m] : rd});
    if (!wr) model_rdata[m] = rd;
  endtask

  task automatic m_drive(input int m, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_addr = addr; bus.m0_is_write = wr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = 1'b1; bus.m1_addr = addr; bus.m1_is_write = wr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic m_release(input int m);
    if (m == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  // leaves req high so a back-to-back call forms a continuous request
  task automatic m_access(input int m, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, output int cycles);
    bit got = 0;
    m_drive(m, addr, wr, wdata);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50M);
      cycles++;
      if ((m == 0) ? bus.m0_ack : bus.m1_ack) begin
        got = 1;
        break;
      end
    end
    check($sformatf("ack_wait_m%0d", m), got, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, dbg_state, 2'd0);
    check({tag, "_grant"}, bus.grant, 1'b0);
    check({tag, "_dev_req"}, bus.dev_req, 1'b0);
    check({tag, "_dev_is_write"}, bus.dev_is_write, 1'b0);
    check({tag, "_dev_addr"}, bus.dev_addr, 32'h0);
    check({tag, "_dev_data_out"}, bus.dev_data_out, 32'h0);
    check({tag, "_m0_ack"}, bus.m0_ack, 1'b0);
    check({tag, "_m1_ack"}, bus.m1_ack, 1'b0);
    check({tag, "_m0_rdata"}, bus.m0_rdata, 32'h0);
    check({tag, "_m1_rdata"}, bus.m1_rdata, 32'h0);
    check({tag, "_err"}, bus.err, 1'b0);
  endtask

  logic [31:0] c_addr [6];
  logic        c_wr [6];
  logic [31:0] c_wdata [6];
  logic [31:0] c_rd [6];

  initial begin
    int  lat;
    bit  reached;
    bus.m0_req = 1'b0; bus.m0_addr = 32'h0; bus.m0_is_write = 1'b0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_addr = 32'h0; bus.m1_is_write = 1'b0; bus.m1_wdata = 32'h0;
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
    mem_busy_cycles = 2;
    rst = 1'b0;
    repeat (3) @(negedge clk50M);
    check_reset("por");

    // first tie after reset plus continuous contention: service order 0,1,0,1,0,1
    c_addr  = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    c_wr    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    c_wdata = '{32'h0, 32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0, 32'h0};
    c_rd    = '{32'h11110001, 32'h0, 32'h0, 32'h22220004, 32'h11110003, 32'h22220005};
    for (int k = 0; k < 6; k++) expect_access(k % 2, c_addr[k], c_wr[k], c_wdata[k], c_rd[k]);
    rst = 1'b1;
    fork
      begin : drv0
        int l0;
        for (int k = 0; k < 6; k += 2) m_access(0, c_addr[k], c_wr[k], c_wdata[k], l0);
        m_release(0);
      end
      begin : drv1
        int l1;
        for (int k = 1; k < 6; k += 2) m_access(1, c_addr[k], c_wr[k], c_wdata[k], l1);
        m_release(1);
      end
    join
    repeat (2) @(negedge clk50M);

    // single read, busy 3 cycles
    mem_busy_cycles = 3;
    expect_access(0, 32'h0000_0010, 1'b0, 32'h0, 32'h1234_5678);
    m_access(0, 32'h0000_0010, 1'b0, 32'h0, lat);
    m_release(0);
    check("read_latency", lat, 5);
    repeat (2) @(negedge clk50M);

    // single write from master 1, memory never busy: minimum latency
    mem_busy_cycles = 0;
    expect_access(1, 32'h8000_1000, 1'b1, 32'hA5A5_A5A5, 32'h0);
    m_access(1, 32'h8000_1000, 1'b1, 32'hA5A5_A5A5, lat);
    m_release(1);
    check("write_latency", lat, 4);
    @(negedge clk50M);
    check("write_grant", bus.grant, 1'b1);
    repeat (2) @(negedge clk50M);

    // reset while the access sits in WAIT with busy high
    mem_busy_cycles = 10;
    exp_dev_q.push_back({1'b0, 32'h0000_3000, 32'h0});
    mem_data_q.push_back(32'h7777_7777);
    m_drive(1, 32'h0000_3000, 1'b0, 32'h0);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50M);
      if (dbg_state == 2'd2) begin
        reached = 1;
        break;
      end
    end
    check("reach_wait", reached, 1'b1);
    @(negedge clk50M);
    rst = 1'b0;
    bus.m1_req = 1'b0;
    model_rdata[0] = 32'h0;
    model_rdata[1] = 32'h0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk50M);
    rst = 1'b1;
    repeat (12) @(negedge clk50M);
    mem_busy_cycles = 1;
    expect_access(0, 32'h0000_0040, 1'b0, 32'h0, 32'h0BAD_F00D);
    m_access(0, 32'h0000_0040, 1'b0, 32'h0, lat);
    m_release(0);
    check("post_rst_latency", lat, 4);
    repeat (2) @(negedge clk50M);

`ifdef MEM_ARB_TIMEOUT_EN
    // dev_busy stuck high: abort after 8 busy WAIT cycles
    mem_busy_cycles = 40;
    exp_dev_q.push_back({1'b0, 32'h0000_0500, 32'h0});
    mem_data_q.push_back(32'h5555_5555);
    exp_ack_q.push_back({1'b1, 32'hDEAD_BEEF});
    model_rdata[1] = 32'hDEAD_BEEF;
    m_access(1, 32'h0000_0500, 1'b0, 32'h0, lat);
    m_release(1);
    check("timeout_latency", lat, 10);
    check("err_set", bus.err, 1'b1);
    repeat (45) @(negedge clk50M);
    mem_busy_cycles = 1;
    expect_access(0, 32'h0000_0044, 1'b0, 32'h0, 32'h600D_DA7A);
    m_access(0, 32'h0000_0044, 1'b0, 32'h0, lat);
    m_release(0);
    check("err_sticky", bus.err, 1'b1);
`else
    check("err_tied_low", bus.err, 1'b0);
`endif

    repeat (4) @(negedge clk50M);
    check("dev_q_drained", exp_dev_q.size(), 0);
    check("ack_q_drained", exp_ack_q.size(), 0);
    check("mem_q_drained", mem_data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
